// File: rtl/exalu_issue.sv
// Issue, operand and writeback controller for the 256-bit extended ALU.
// Holds the xr0-xr7 register file and sequences the multi-cycle AES write-enable protocol.
module exalu_issue #(
    parameter int TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         issue_valid,
    output logic         issue_ready,
    input  logic [2:0]   issue_op,
    input  logic [4:0]   issue_rd,
    input  logic [2:0]   issue_rs1,
    input  logic [2:0]   issue_rs2,
    input  logic         issue_use_scalar,
    input  logic [31:0]  issue_scalar,
    output logic         alu_we,
    output logic [2:0]   alu_control,
    output logic [255:0] alu_d1,
    output logic [255:0] alu_d2,
    input  logic [255:0] alu_out,
    input  logic         alu_busy,
    output logic         scalar_wb_valid,
    output logic [4:0]   scalar_wb_rd,
    output logic [31:0]  scalar_wb_data,
    output logic         done,
    output logic         err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, EXEC, LAUNCH, WAIT, FIN, WB, ERR} stateType;

    stateType       state;
    stateType       nextState;
    logic [2:0]     opReg;
    logic [4:0]     rdReg;
    logic [255:0]   result;
    logic [255:0]   xr [8];
    logic [CW-1:0]  waitCnt;
    logic [CW-1:0]  waitNext;
    logic           transfer;
    logic           captureResult;
    logic           clearCnt;
    logic           incCnt;
    logic           xrWrite;
    logic           scalarOp;
    logic           aesIssue;

    assign scalarOp       = (opReg == 3'd3) || (opReg == 3'd6);
    assign aesIssue       = (issue_op == 3'd1) || (issue_op == 3'd2);
    assign waitNext       = waitCnt + CW'(1);
    assign scalar_wb_rd   = rdReg;
    assign scalar_wb_data = result[31:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Operands are latched at issue, so a destination equal to a source
    // still sees the old value; the register file only changes in WB.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            opReg   <= 3'd0;
            rdReg   <= 5'd0;
            alu_d1  <= '0;
            alu_d2  <= '0;
            result  <= '0;
            waitCnt <= '0;
            for (int i = 0; i < 8; i++) begin
                xr[i] <= '0;
            end
        end else begin
            if (transfer) begin
                opReg  <= issue_op;
                rdReg  <= issue_rd;
                alu_d1 <= xr[issue_rs1];
                alu_d2 <= issue_use_scalar ? {224'b0, issue_scalar} : xr[issue_rs2];
            end
            if (captureResult) begin
                result <= alu_out;
            end
            if (clearCnt) begin
                waitCnt <= '0;
            end else if (incCnt) begin
                waitCnt <= waitNext;
            end
            if (xrWrite) begin
                xr[rdReg[2:0]] <= result;
            end
        end
    end

    always_comb begin
        nextState       = state;
        issue_ready     = 1'b0;
        alu_we          = 1'b0;
        alu_control     = opReg;
        scalar_wb_valid = 1'b0;
        done            = 1'b0;
        err             = 1'b0;
        transfer        = 1'b0;
        captureResult   = 1'b0;
        clearCnt        = 1'b0;
        incCnt          = 1'b0;
        xrWrite         = 1'b0;
        case (state)
            IDLE: begin
                issue_ready = 1'b1;
                alu_control = 3'd0;
                if (issue_valid) begin
                    transfer  = 1'b1;
                    nextState = aesIssue ? LAUNCH : EXEC;
                end
            end
            EXEC: begin
                captureResult = 1'b1;
                nextState     = WB;
            end
            LAUNCH: begin
                alu_we    = 1'b1;
                clearCnt  = 1'b1;
                nextState = WAIT;
            end
            // alu_we stays high throughout so the engine is never relaunched mid-run.
            WAIT: begin
                alu_we = 1'b1;
                if (!alu_busy) begin
                    nextState = FIN;
                end else begin
                    incCnt = 1'b1;
                    if (waitNext == CW'(TIMEOUT)) begin
                        nextState = ERR;
                    end
                end
            end
            FIN: begin
                alu_we        = 1'b1;
                captureResult = 1'b1;
                nextState     = WB;
            end
            WB: begin
                done = 1'b1;
                if (scalarOp) begin
                    scalar_wb_valid = 1'b1;
                end else begin
                    xrWrite = 1'b1;
                end
                nextState = IDLE;
            end
            ERR: begin
                err       = 1'b1;
                nextState = ERR;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule
